// File: rtl/muldiv_hilo_if.sv
// Operation and result bundle between the EXE stage and the HI/LO multiply unit.
interface muldiv_hilo_if;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  busy, stall_req, done, rd_data, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output busy, stall_req, done, rd_data, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// HI/LO register pair with a 32-cycle radix-2 shift-add multiplier (MULT/MULTU/MUL).
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate into HI/LO.
module muldiv_hilo (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_hilo_if.slave mdu
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FINISH
  } state_t;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] mcand_reg;
  logic [63:0] prod_reg;
  logic        neg_reg;
  logic [3:0]  op_reg;
  logic        busy_reg;
  logic        done_reg;

  logic        is_mul_op;
  logic        is_signed_op;
  logic        is_hilo_op;
  logic        accept;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        neg_next;
  logic [32:0] step_sum;
  logic [63:0] prod_next;
  logic [63:0] prod_signed;
  logic [63:0] hilo_next;
  logic [31:0] rd_next;

  always_comb begin
    is_mul_op    = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU) || (mdu.op == OP_MUL);
    is_signed_op = (mdu.op == OP_MULT) || (mdu.op == OP_MUL);
`ifdef MULDIV_MADD_EN
    if ((mdu.op >= OP_MADD) && (mdu.op <= OP_MSUBU)) begin
      is_mul_op = 1'b1;
    end
    if ((mdu.op == OP_MADD) || (mdu.op == OP_MSUB)) begin
      is_signed_op = 1'b1;
    end
`endif
    is_hilo_op = is_mul_op || (mdu.op == OP_MTHI) || (mdu.op == OP_MTLO)
                 || (mdu.op == OP_MFHI) || (mdu.op == OP_MFLO);
  end

  assign accept = mdu.op_valid && !busy_reg && !mdu.flush;

  // Signed ops multiply magnitudes; the sign is reapplied once in FINISH.
  assign abs_a    = (is_signed_op && mdu.src_a[31]) ? (~mdu.src_a + 32'd1) : mdu.src_a;
  assign abs_b    = (is_signed_op && mdu.src_b[31]) ? (~mdu.src_b + 32'd1) : mdu.src_b;
  assign neg_next = is_signed_op && (mdu.src_a[31] ^ mdu.src_b[31]);

  // Multiplier sits in prod_reg[31:0] and is shifted out LSB-first as the
  // partial product grows in the upper half.
  assign step_sum    = {1'b0, prod_reg[63:32]} + (prod_reg[0] ? {1'b0, mcand_reg} : 33'd0);
  assign prod_next   = {step_sum, prod_reg[31:1]};
  assign prod_signed = neg_reg ? (~prod_reg + 64'd1) : prod_reg;

  always_comb begin
    hilo_next = {hi_reg, lo_reg};
    case (op_reg)
      OP_MULT, OP_MULTU: hilo_next = prod_signed;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU: hilo_next = {hi_reg, lo_reg} + prod_signed;
      OP_MSUB, OP_MSUBU: hilo_next = {hi_reg, lo_reg} - prod_signed;
`endif
      default:           hilo_next = {hi_reg, lo_reg};
    endcase
  end

  always_comb begin
    rd_next = 32'd0;
    if (accept && (mdu.op == OP_MFHI)) begin
      rd_next = hi_reg;
    end else if (accept && (mdu.op == OP_MFLO)) begin
      rd_next = lo_reg;
    end else if ((state_reg == ST_FINISH) && (op_reg == OP_MUL) && !mdu.flush) begin
      rd_next = prod_signed[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 5'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      mcand_reg <= 32'd0;
      prod_reg  <= 64'd0;
      neg_reg   <= 1'b0;
      op_reg    <= 4'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (mdu.flush) begin
        // Abandon whatever is in flight; HI/LO keep their architectural value.
        state_reg <= ST_IDLE;
        cnt_reg   <= 5'd0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (mdu.op_valid) begin
              if (mdu.op == OP_MTHI) begin
                hi_reg <= mdu.src_a;
              end else if (mdu.op == OP_MTLO) begin
                lo_reg <= mdu.src_a;
              end else if (is_mul_op) begin
                op_reg    <= mdu.op;
                mcand_reg <= abs_a;
                prod_reg  <= {32'd0, abs_b};
                neg_reg   <= neg_next;
                cnt_reg   <= 5'd0;
                busy_reg  <= 1'b1;
                state_reg <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            prod_reg <= prod_next;
            cnt_reg  <= cnt_reg + 5'd1;
            if (cnt_reg == 5'd31) begin
              state_reg <= ST_FINISH;
              done_reg  <= 1'b1;
            end
          end
          ST_FINISH: begin
            {hi_reg, lo_reg} <= hilo_next;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mdu.busy      = busy_reg;
  assign mdu.stall_req = mdu.op_valid && busy_reg && is_hilo_op;
  assign mdu.done      = done_reg && !mdu.flush;
  assign mdu.rd_data   = rd_next;
  assign mdu.hi        = hi_reg;
  assign mdu.lo        = lo_reg;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: directed corner cases plus random ops
// against a plain 64-bit arithmetic model of HI/LO.
module tb_muldiv_hilo;
`ifdef MULDIV_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  muldiv_hilo_if bus();

  muldiv_hilo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (bus)
  );

  typedef struct {
    bit          is_mf;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_vec = 0;
  int          n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: HI/LO as one 64-bit value, products by plain arithmetic.
  function automatic void model_issue(input logic [3:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [63:0] hl;
    logic [63:0] sp;
    logic [63:0] up;
    exp_t        e;
    bit          push_it;
    sp = 64'(longint'($signed(a)) * longint'($signed(b)));
    up = {32'd0, a} * {32'd0, b};
    hl = {m_hi, m_lo};
    push_it = 1'b0;
    e.is_mf = 1'b0;
    e.rd    = 32'd0;
    case (o)
      4'd1:  begin hl = sp; push_it = 1'b1; end
      4'd2:  begin hl = up; push_it = 1'b1; end
      4'd3:  hl[63:32] = a;
      4'd4:  hl[31:0] = a;
      4'd5:  begin e.rd = sp[31:0]; push_it = 1'b1; end
`ifdef MULDIV_MADD_EN
      4'd6:  begin hl = hl + sp; push_it = 1'b1; end
      4'd7:  begin hl = hl + up; push_it = 1'b1; end
      4'd8:  begin hl = hl - sp; push_it = 1'b1; end
      4'd9:  begin hl = hl - up; push_it = 1'b1; end
`endif
      4'd10: begin e.is_mf = 1'b1; e.rd = hl[63:32]; push_it = 1'b1; end
      4'd11: begin e.is_mf = 1'b1; e.rd = hl[31:0]; push_it = 1'b1; end
      default: ;
    endcase
    m_hi = hl[63:32];
    m_lo = hl[31:0];
    e.hi = m_hi;
    e.lo = m_lo;
    if (push_it) sb.push_back(e);
  endfunction

  // Presents one op from the cycle after the next edge and holds it until accepted.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit use_model, output int stalls);
    int cyc;
    if (use_model) model_issue(o, a, b);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.src_a    = a;
    bus.src_b    = b;
    stalls = 0;
    cyc    = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      if (bus.stall_req) stalls++;
      cyc++;
      if (cyc > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: op %0d pending %0d cycles, required acceptance", o, cyc);
        break;
      end
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op       = 4'd0;
  endtask

  task automatic wait_idle(output int busy_cyc, output int done_at);
    busy_cyc = 0;
    done_at  = -1;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cyc++;
      if (bus.done && (done_at < 0)) done_at = busy_cyc;
      if (busy_cyc > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout: busy for %0d cycles, required idle", busy_cyc);
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops an expectation on every done pulse and every accepted MFHI/MFLO.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: done=1 with no multiply outstanding (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("done_kind", 32'(bus.done && mon_e.is_mf), 32'd0);
          check("finish_rd_data", bus.rd_data, mon_e.rd);
          @(posedge clk); #1;
          check("finish_hi", bus.hi, mon_e.hi);
          check("finish_lo", bus.lo, mon_e.lo);
        end
      end else if (bus.op_valid && !bus.busy && !bus.flush &&
                   ((bus.op == 4'd10) || (bus.op == 4'd11))) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_mf: MF accepted with empty scoreboard (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("mf_kind", 32'(mon_e.is_mf), 32'd1);
          check("mf_rd_data", bus.rd_data, mon_e.rd);
        end
      end else if (!bus.op_valid) begin
        check("idle_rd_data", bus.rd_data, 32'd0);
      end
    end
  end

  initial begin
    int st;
    int bc;
    int da;
    logic [3:0] ro;
    m_hi = 32'd0;
    m_lo = 32'd0;
    bus.op_valid = 1'b0;
    bus.op       = 4'd0;
    bus.src_a    = 32'd0;
    bus.src_b    = 32'd0;
    bus.flush    = 1'b0;
    rst_n        = 1'b0;
    #3;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_stall", 32'(bus.stall_req), 32'd0);
    check("reset_rd_data", bus.rd_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed MULT with negative operand: 33-cycle busy, done on the last one.
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, st);
    wait_idle(bc, da);
    check("mult_busy_cycles", 32'(bc), 32'd33);
    check("mult_done_cycle", 32'(da), 32'd33);
    check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", bus.lo, 32'hFFFF_FFFA);

    issue(4'd2, 32'h8000_0000, 32'h8000_0000, 1'b1, st);
    wait_idle(bc, da);
    check("multu_min_hi", bus.hi, 32'h4000_0000);
    check("multu_min_lo", bus.lo, 32'h0000_0000);
    issue(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, st);
    wait_idle(bc, da);
    check("mult_min_hi", bus.hi, 32'h4000_0000);
    check("mult_min_lo", bus.lo, 32'h0000_0000);

    // MTHI/MTLO then accumulate and subtract (NONE when the accumulator is absent).
    issue(4'd3, 32'd5, 32'd0, 1'b1, st);
    issue(4'd4, 32'd7, 32'd0, 1'b1, st);
    issue(4'd7, 32'd2, 32'd3, 1'b1, st);
    issue(4'd8, 32'd1, 32'd1, 1'b1, st);
    issue(4'd11, 32'd0, 32'd0, 1'b1, st);
    issue(4'd10, 32'd0, 32'd0, 1'b1, st);
    wait_idle(bc, da);
    check("acc_seq_hi", bus.hi, m_hi);
    check("acc_seq_lo", bus.lo, m_lo);

    // MFLO presented one cycle after the MULT is taken stalls until FINISH ends.
    issue(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, st);
    issue(4'd11, 32'd0, 32'd0, 1'b1, st);
    check("mflo_stall_cycles", 32'(st), 32'd32);

    issue(4'd5, 32'hFFFF_FFF9, 32'd6, 1'b1, st);
    issue(4'd6, 32'd9, 32'd11, 1'b1, st);
    check("madd_busy_stall", 32'(st), MADD_ON ? 32'd32 : 32'd0);
    wait_idle(bc, da);
    issue(4'd2, 32'd100, 32'd200, 1'b1, st);
    issue(4'd13, 32'd1, 32'd1, 1'b1, st);
    check("none_busy_stall", 32'(st), 32'd0);
    wait_idle(bc, da);

    issue(4'd9, 32'd4, 32'd4, 1'b1, st);
    @(negedge clk);
    check("madd_idle_busy", 32'(bus.busy), 32'(MADD_ON));
    wait_idle(bc, da);
    check("madd_idle_hi", bus.hi, m_hi);
    check("madd_idle_lo", bus.lo, m_lo);

    // Flush at CALC cycle 10 abandons the multiply.
    issue(4'd3, 32'hAAAA_0001, 32'd0, 1'b1, st);
    issue(4'd4, 32'h5555_0002, 32'd0, 1'b1, st);
    issue(4'd1, 32'd4, 32'd4, 1'b0, st);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_hi", bus.hi, m_hi);
    check("flush_lo", bus.lo, m_lo);
    repeat (40) @(posedge clk);
    #1;
    check("flush_late_lo", bus.lo, m_lo);

    // Flush in the same cycle as an MTHI blocks the write.
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = 4'd3;
    bus.src_a    = 32'hDEAD_BEEF;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op       = 4'd0;
    bus.flush    = 1'b0;
    check("flush_blocks_mthi", bus.hi, m_hi);

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      issue(ro, rand_operand(), rand_operand(), 1'b1, st);
      $display("op %0d: code %0d hi=%08h lo=%08h", i, ro, m_hi, m_lo);
    end
    wait_idle(bc, da);
    check("random_hi", bus.hi, m_hi);
    check("random_lo", bus.lo, m_lo);

    // Asynchronous reset in the middle of CALC.
    issue(4'd3, 32'h0000_1234, 32'd0, 1'b1, st);
    issue(4'd1, 32'd77, 32'd99, 1'b0, st);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_stall", 32'(bus.stall_req), 32'd0);
    check("midreset_hi", bus.hi, 32'd0);
    check("midreset_lo", bus.lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("postreset_hi", bus.hi, 32'd0);
    check("postreset_lo", bus.lo, 32'd0);
    check("postreset_busy", 32'(bus.busy), 32'd0);

    issue(4'd6, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, st);
    wait_idle(bc, da);
    check("postreset_madd_hi", bus.hi, m_hi);
    check("postreset_madd_lo", bus.lo, m_lo);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op_valid, input, 1, EXE-stage HI/LO operation present this cycle.
REQ-004 SHALL have port op, input, 4, operation code: 0 NONE, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MUL, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU, 10 MFHI, 11 MFLO; codes 12-15 are treated as NONE.
REQ-005 SHALL have port src_a, input, 32, forwarded rs value.
REQ-006 SHALL have port src_b, input, 32, forwarded rt value.
REQ-007 SHALL have port flush, input, 1, pipeline flush on exception or eret.
REQ-008 SHALL have port busy, output, 1, multiply in progress.
REQ-009 SHALL have port stall_req, output, 1, request to freeze IF/ID/EXE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a multiply completes.
REQ-011 SHALL have port rd_data, output, 32, GPR write value for MFHI, MFLO and MUL.
REQ-012 SHALL have ports hi and lo, output, 32 each, architectural HI/LO.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FINISH -> IDLE; busy = (state != IDLE).
REQ-014 SHALL accept an operation when op_valid=1, ~busy and ~flush; stall_req = op_valid & busy & (op in 1..11).
REQ-015 MTHI/MTLO SHALL write src_a to hi/lo at the accepting edge and stay in IDLE.
REQ-016 MFHI/MFLO SHALL drive rd_data = hi/lo combinationally when accepted, with no state change.
REQ-017 Codes 1,2,5-9 SHALL latch |src_a|, |src_b|, result sign and op at acceptance, then enter CALC with a 5-bit counter at 0.
REQ-018 Signed ops (MULT, MUL, MADD, MSUB) SHALL use two's-complement magnitudes; unsigned ops SHALL use the raw operands.
REQ-019 CALC SHALL perform one radix-2 shift-add step per cycle for exactly 32 cycles, leaving a 64-bit unsigned product, then go to FINISH.
REQ-020 FINISH SHALL negate the product if the result sign is set, then: MULT/MULTU {hi,lo}=P; MADD/MADDU {hi,lo}+=P; MSUB/MSUBU {hi,lo}-=P (64-bit modulo 2^64); MUL leaves hi/lo unchanged and drives rd_data=P[31:0].
REQ-021 done SHALL be high only in the FINISH cycle; latency from acceptance edge to hi/lo update is 33 edges; busy is high for 33 cycles.
REQ-022 An op presented during FINISH SHALL be stalled; it is accepted on the following cycle and sees the updated hi/lo.
REQ-023 flush SHALL return the FSM to IDLE at the next edge from any state, without writing hi/lo and without pulsing done; flush overrides acceptance in the same cycle.
REQ-024 rd_data SHALL be 0 when no MFHI, MFLO or FINISH-MUL is active.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0 and stall_req=0 (while op_valid=0), independent of clk.
REQ-026 A reset mid-multiply SHALL discard the operation; no hi/lo write follows deassertion.

Configuration
REQ-027 Macro MULDIV_MADD_EN defined: codes 6-9 behave per REQ-020.
REQ-028 Macro MULDIV_MADD_EN undefined: codes 6-9 are treated as NONE (no stall, no state change) and the accumulate/subtract adder is omitted.

Verification
REQ-029 MULT src_a=0xFFFFFFFE, src_b=3 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, with done pulsed once.
REQ-030 MULTU 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; MULT on the same operands -> hi=0x40000000, lo=0.
REQ-031 MTHI 5, MTLO 7, then MADDU 2x3 -> lo=0x0000000D, hi=5; then MSUB 1x1 -> lo=0x0000000C.
REQ-032 MFLO issued 1 cycle after MULT -> stall_req high for 32 cycles, then rd_data equals the new lo.
REQ-033 flush asserted at CALC cycle 10 of MULT 4x4 -> hi/lo retain their prior values, done never pulses, busy=0 next cycle.
REQ-034 rst_n pulsed low mid-CALC -> outputs 0 immediately; with MULDIV_MADD_EN undefined, MADD leaves hi/lo unchanged and busy=0.
